// File: rtl/mealy_stepper.sv
// Sequencing controller for one Mealy FSM core: loads the core with a start
// state, steps it through a packed switch-input sequence and captures every output.
module mealy_stepper #(
    parameter int MAX_STEPS = 16,
    parameter int STEP_GAP  = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [2:0]                     init_state,
    input  logic [2*MAX_STEPS-1:0]         seq_in,
    input  logic [$clog2(MAX_STEPS+1)-1:0] num_steps,
    input  logic                           abort,
    output logic                           ready,
    output logic                           done,
    output logic                           aborted,
    output logic [MAX_STEPS-1:0]           result_bits,
    output logic [2:0]                     final_state,
    output logic                           core_reset,
    output logic                           core_ctrl,
    output logic [1:0]                     core_sw,
    output logic [2:0]                     core_state_in,
    input  logic                           core_out,
    input  logic [2:0]                     core_state
);
    localparam int IW = $clog2(MAX_STEPS + 1);
    localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam logic [IW-1:0] MAX_N    = IW'(MAX_STEPS);
    localparam logic [GW-1:0] GAP_LAST = GW'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_STEP    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]             r_state;
    logic [2*MAX_STEPS-1:0] r_seq;
    logic [IW-1:0]          r_num;
    logic [IW-1:0]          r_idx;
    logic [GW-1:0]          r_gap_cnt;
    logic [MAX_STEPS-1:0]   r_result;
    logic [2:0]             r_final;
    logic [2:0]             r_state_in;
    logic                   r_ready;
    logic                   r_done;
    logic                   r_aborted;
    logic                   r_core_reset;
    logic                   r_core_ctrl;
    logic [1:0]             r_core_sw;

    logic [2:0]             w_next_state;
    logic                   w_abort_take;
    logic                   w_accept;
    logic [IW-1:0]          w_idx_inc;
    logic [IW-1:0]          w_sw_idx;
    logic [IW-1:0]          w_num_clamped;

    function automatic logic [1:0] pick_sw(input logic [2*MAX_STEPS-1:0] seq,
                                           input logic [IW-1:0] idx);
        pick_sw = 2'b00;
        for (int k = 0; k < MAX_STEPS; k++) begin
            pick_sw = (idx == IW'(k)) ? seq[2*k +: 2] : pick_sw;
        end
    endfunction

    // Job acceptance, step-count clamp and the index that feeds the next STEP
    always_comb begin
        w_accept  = (r_state == S_IDLE) && start;
        w_idx_inc = r_idx + IW'(1);
        if (num_steps > MAX_N) begin
            w_num_clamped = MAX_N;
        end else begin
            w_num_clamped = num_steps;
        end
        if (r_state == S_CAPTURE) begin
            w_sw_idx = w_idx_inc;
        end else begin
            w_sw_idx = r_idx;
        end
    end

    // Next-state logic; an abort overrides every busy state
    always_comb begin
        w_next_state = r_state;
        w_abort_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                if (r_num == '0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_STEP;
                end
            end
            S_STEP: w_next_state = S_CAPTURE;
            S_CAPTURE: begin
                if (w_idx_inc == r_num) begin
                    w_next_state = S_DONE;
                end else if (STEP_GAP > 0) begin
                    w_next_state = S_GAP;
                end else begin
                    w_next_state = S_STEP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = S_STEP;
                end else begin
                    w_next_state = S_GAP;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_abort_take = 1'b1;
            w_next_state = S_IDLE;
        end else begin
            w_abort_take = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Control outputs are registered from the next state so the core pins never glitch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_core_reset <= 1'b0;
            r_core_ctrl  <= 1'b0;
            r_core_sw    <= 2'b00;
        end else begin
            r_ready      <= (w_next_state == S_IDLE);
            r_done       <= (w_next_state == S_DONE);
            r_aborted    <= w_abort_take;
            r_core_reset <= (w_next_state == S_LOAD);
            r_core_ctrl  <= (w_next_state == S_STEP);
            r_core_sw    <= (w_next_state == S_STEP) ? pick_sw(r_seq, w_sw_idx) : 2'b00;
        end
    end

    // Job latch, step index, gap counter and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq      <= '0;
            r_num      <= '0;
            r_idx      <= '0;
            r_gap_cnt  <= '0;
            r_result   <= '0;
            r_final    <= 3'd0;
            r_state_in <= 3'd0;
        end else if (w_accept) begin
            r_state_in <= init_state;
            r_seq      <= seq_in;
            r_num      <= w_num_clamped;
            r_result   <= '0;
            r_idx      <= '0;
            r_gap_cnt  <= '0;
        end else if (!w_abort_take) begin
            if ((r_state == S_LOAD) && (r_num == '0)) begin
                r_final <= r_state_in;
            end
            if (r_state == S_CAPTURE) begin
                for (int k = 0; k < MAX_STEPS; k++) begin
                    if (r_idx == IW'(k)) begin
                        r_result[k] <= core_out;
                    end
                end
                r_final <= core_state;
                r_idx   <= w_idx_inc;
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // The core is held in reset for as long as the block itself is
    assign core_reset    = r_core_reset | ~reset_n;
    assign core_ctrl     = r_core_ctrl;
    assign core_sw       = r_core_sw;
    assign core_state_in = r_state_in;
    assign ready         = r_ready;
    assign done          = r_done;
    assign aborted       = r_aborted;
    assign result_bits   = r_result;
    assign final_state   = r_final;

endmodule

// File: tb/tb_mealy_stepper.sv
// Self-checking bench: two steppers (gap 0 and gap 2), each driving a behavioural
// Mealy core, compared against a per-job reference computed step by step.
module tb_mealy_stepper;
    localparam int GAP_B = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        sel;
    logic [2:0]  init_state;
    logic [31:0] seq_in;
    logic [4:0]  num_steps;

    logic        a_ready, a_done, a_aborted, a_core_reset, a_core_ctrl, a_core_out;
    logic [15:0] a_result;
    logic [2:0]  a_final, a_core_state_in, a_cst;
    logic [1:0]  a_core_sw;
    logic        b_ready, b_done, b_aborted, b_core_reset, b_core_ctrl, b_core_out;
    logic [15:0] b_result;
    logic [2:0]  b_final, b_core_state_in, b_cst;
    logic [1:0]  b_core_sw;

    logic        o_ready, o_done, o_aborted, o_core_reset, o_core_ctrl;
    logic [15:0] o_result;
    logic [2:0]  o_final, o_core_state_in;
    logic [1:0]  o_core_sw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mealy_stepper #(.MAX_STEPS(16), .STEP_GAP(0)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start & ~sel), .init_state(init_state),
        .seq_in(seq_in), .num_steps(num_steps), .abort(abort & ~sel),
        .ready(a_ready), .done(a_done), .aborted(a_aborted), .result_bits(a_result),
        .final_state(a_final), .core_reset(a_core_reset), .core_ctrl(a_core_ctrl),
        .core_sw(a_core_sw), .core_state_in(a_core_state_in),
        .core_out(a_core_out), .core_state(a_cst)
    );

    mealy_stepper #(.MAX_STEPS(16), .STEP_GAP(GAP_B)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start & sel), .init_state(init_state),
        .seq_in(seq_in), .num_steps(num_steps), .abort(abort & sel),
        .ready(b_ready), .done(b_done), .aborted(b_aborted), .result_bits(b_result),
        .final_state(b_final), .core_reset(b_core_reset), .core_ctrl(b_core_ctrl),
        .core_sw(b_core_sw), .core_state_in(b_core_state_in),
        .core_out(b_core_out), .core_state(b_cst)
    );

    assign o_ready         = sel ? b_ready : a_ready;
    assign o_done          = sel ? b_done : a_done;
    assign o_aborted       = sel ? b_aborted : a_aborted;
    assign o_result        = sel ? b_result : a_result;
    assign o_final         = sel ? b_final : a_final;
    assign o_core_reset    = sel ? b_core_reset : a_core_reset;
    assign o_core_ctrl     = sel ? b_core_ctrl : a_core_ctrl;
    assign o_core_sw       = sel ? b_core_sw : a_core_sw;
    assign o_core_state_in = sel ? b_core_state_in : a_core_state_in;

    // Core transition table, {next_state, out}; states 2..7 use an arbitrary rule
    function automatic logic [3:0] core_fn(input logic [2:0] s, input logic [1:0] sw);
        case (s)
            3'd0: case (sw)
                2'd0: core_fn = {3'd0, 1'b1};
                2'd1: core_fn = {3'd0, 1'b0};
                2'd2: core_fn = {3'd1, 1'b1};
                default: core_fn = {3'd1, 1'b1};
            endcase
            3'd1: case (sw)
                2'd0: core_fn = {3'd0, 1'b0};
                2'd1: core_fn = {3'd1, 1'b1};
                2'd2: core_fn = {3'd1, 1'b1};
                default: core_fn = {3'd1, 1'b0};
            endcase
            default: core_fn = {s + {1'b0, sw} + 3'd1, s[0] ^ sw[1]};
        endcase
    endfunction

    // Behavioural cores with registered output
    always_ff @(posedge clk) begin
        if (a_core_reset) begin
            a_cst <= a_core_state_in; a_core_out <= 1'b0;
        end else if (a_core_ctrl) begin
            {a_cst, a_core_out} <= core_fn(a_cst, a_core_sw);
        end
    end

    always_ff @(posedge clk) begin
        if (b_core_reset) begin
            b_cst <= b_core_state_in; b_core_out <= 1'b0;
        end else if (b_core_ctrl) begin
            {b_cst, b_core_out} <= core_fn(b_cst, b_core_sw);
        end
    end

    // Called at a negedge with the selected DUT idle; returns at the negedge after done
    task automatic run_job(input logic [2:0] init, input logic [31:0] seq, input logic [4:0] num,
                           input bit abort_with_start, input bit busy_start);
        int gap, n, exp_done, c, done_cycle, ctrl_err, rst_err;
        logic [2:0]  s;
        logic [3:0]  t;
        logic [15:0] exp_res;
        logic        exp_ctrl;
        gap = sel ? GAP_B : 0;
        n = (num > 5'd16) ? 16 : int'(num);
        s = init;
        exp_res = 16'h0000;
        for (int k = 0; k < n; k++) begin
            t = core_fn(s, seq[2*k +: 2]);
            exp_res[k] = t[0];
            s = t[3:1];
        end
        exp_done = (n == 0) ? 2 : 2 + 2*n + gap*(n-1);
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL job_ready_at_start got %b want 1", o_ready); end
        init_state = init; seq_in = seq; num_steps = num; start = 1'b1; abort = abort_with_start;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        c = 1; done_cycle = -1; ctrl_err = 0; rst_err = 0;
        while (done_cycle < 0 && c < 300) begin
            exp_ctrl = (n > 0) && (c >= 2) && ((c-2) % (2+gap) == 0) && ((c-2)/(2+gap) < n);
            if (o_core_ctrl !== exp_ctrl) ctrl_err++;
            if (o_core_reset !== (c == 1)) rst_err++;
            if (o_done === 1'b1) begin
                done_cycle = c;
            end else begin
                if (busy_start && c == 2) begin
                    start = 1'b1; init_state = ~init; seq_in = ~seq; num_steps = 5'd3;
                end
                @(negedge clk);
                start = 1'b0;
                c++;
            end
        end
        checks++;
        if (done_cycle != exp_done) begin errors++; $display("FAIL done_cycle got %0d want %0d", done_cycle, exp_done); end
        checks++;
        if (ctrl_err != 0) begin errors++; $display("FAIL core_ctrl_pattern got %0d bad cycles want 0", ctrl_err); end
        checks++;
        if (rst_err != 0) begin errors++; $display("FAIL core_reset_pattern got %0d bad cycles want 0", rst_err); end
        checks++;
        if (o_result !== exp_res) begin errors++; $display("FAIL result_bits got %h want %h", o_result, exp_res); end
        checks++;
        if (o_final !== s) begin errors++; $display("FAIL final_state got %0d want %0d", o_final, s); end
        checks++;
        if (o_aborted !== 1'b0) begin errors++; $display("FAIL aborted_on_done got %b want 0", o_aborted); end
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_done !== 1'b0) begin
            errors++; $display("FAIL after_done got ready=%b done=%b want ready=1 done=0", o_ready, o_done);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (o_ready !== 1'b1 || o_done !== 1'b0 || o_aborted !== 1'b0) begin
            errors++; $display("FAIL reset_flags got r=%b d=%b a=%b want 1 0 0", o_ready, o_done, o_aborted);
        end
        checks++;
        if (o_core_reset !== 1'b1 || o_core_ctrl !== 1'b0) begin
            errors++; $display("FAIL reset_core_pins got rst=%b ctrl=%b want 1 0", o_core_reset, o_core_ctrl);
        end
        checks++;
        if (o_result !== 16'h0000 || o_final !== 3'd0 || o_core_sw !== 2'd0 || o_core_state_in !== 3'd0) begin
            errors++; $display("FAIL reset_data got res=%h fin=%0d sw=%0d sin=%0d want 0", o_result, o_final, o_core_sw, o_core_state_in);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_core_reset !== 1'b0) begin
            errors++; $display("FAIL post_reset got ready=%b core_reset=%b want 1 0", o_ready, o_core_reset);
        end
    endtask

    task automatic test_basic();
        run_job(3'd0, 32'h0000_001E, 5'd4, 1'b0, 1'b0);
        checks++;
        if (o_result !== 16'h0005 || o_final !== 3'd0) begin
            errors++; $display("FAIL basic_result got %h/%0d want 0005/0", o_result, o_final);
        end
    endtask

    task automatic test_zero_steps();
        run_job(3'd1, $urandom, 5'd0, 1'b0, 1'b0);
        checks++;
        if (o_result !== 16'h0000 || o_final !== 3'd1) begin
            errors++; $display("FAIL zero_steps got %h/%0d want 0000/1", o_result, o_final);
        end
    endtask

    task automatic test_gap_clamp();
        sel = 1'b1;
        run_job(3'($urandom_range(0, 7)), $urandom, 5'd20, 1'b0, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_abort();
        int done_seen;
        init_state = 3'd0; seq_in = 32'h0000_001E; num_steps = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (o_aborted !== 1'b1 || o_ready !== 1'b1 || o_done !== 1'b0 || o_core_ctrl !== 1'b0) begin
            errors++; $display("FAIL abort_flags got a=%b r=%b d=%b c=%b want 1 1 0 0", o_aborted, o_ready, o_done, o_core_ctrl);
        end
        checks++;
        if (o_result !== 16'h0001 || o_final !== 3'd1) begin
            errors++; $display("FAIL abort_partial got %h/%0d want 0001/1", o_result, o_final);
        end
        @(negedge clk);
        checks++;
        if (o_aborted !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL abort_pulse_width got a=%b r=%b want 0 1", o_aborted, o_ready);
        end
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_core_ctrl === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_seen); end
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (o_aborted !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle got a=%b r=%b want 0 1", o_aborted, o_ready);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            sel = (j >= 6);
            run_job(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 20)), 1'b0, 1'b0);
        end
        sel = 1'b0;
    endtask

    task automatic test_async_reset();
        init_state = 3'd2; seq_in = $urandom; num_steps = 5'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_core_ctrl !== 1'b1) begin errors++; $display("FAIL pre_reset_step got %b want 1", o_core_ctrl); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (o_core_ctrl !== 1'b0 || o_core_reset !== 1'b1 || o_ready !== 1'b1 || o_done !== 1'b0) begin
            errors++; $display("FAIL async_reset got c=%b rst=%b r=%b d=%b want 0 1 1 0", o_core_ctrl, o_core_reset, o_ready, o_done);
        end
        checks++;
        if (o_result !== 16'h0000 || o_final !== 3'd0 || o_core_state_in !== 3'd0 || o_core_sw !== 2'd0) begin
            errors++; $display("FAIL async_reset_data got %h/%0d/%0d/%0d want 0", o_result, o_final, o_core_state_in, o_core_sw);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_core_reset !== 1'b0 || o_core_ctrl !== 1'b0) begin
            errors++; $display("FAIL after_release got r=%b rst=%b c=%b want 1 0 0", o_ready, o_core_reset, o_core_ctrl);
        end
        run_job(3'($urandom_range(0, 7)), $urandom, 5'd3, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
        init_state = 3'd0; seq_in = 32'd0; num_steps = 5'd0;
        test_reset();
        test_basic();
        test_zero_steps();
        test_gap_clamp();
        run_job(3'd5, $urandom, 5'd6, 1'b0, 1'b1);
        run_job(3'd3, $urandom, 5'd5, 1'b1, 1'b0);
        test_abort();
        test_abort_idle();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mealy_stepper.md
# mealy_stepper

Sequencing controller for the configurable Mealy FSM cores (2-bit switch input, 3-bit state, 1-bit registered output, state loaded from `state_in` on reset, advanced only when `ctrl_in` is high). The block accepts one job, either from a host or from the board-level test harness. A job is an initial state plus a packed sequence of switch inputs. The block loads the core, steps it once per input, captures every output bit and the final state, then reports completion. It sits between the job source and one core instance and owns that core's `reset`, `ctrl_in`, `sw_in` and `state_in` pins.

## Interface
- `MAX_STEPS`, 16: capacity of the input sequence, in steps.
- `STEP_GAP`, 0: idle cycles inserted between consecutive steps. Not inserted after the last step.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request, accepted when `start && ready`.
- `init_state` in 3: core start state, latched on accept.
- `seq_in` in 2*MAX_STEPS: switch inputs, step k in bits [2k+1:2k]; latched on accept.
- `num_steps` in clog2(MAX_STEPS+1): step count; latched on accept; values above MAX_STEPS clamp to MAX_STEPS.
- `abort` in 1: cancels the job in progress.
- `ready` out 1: high in IDLE only.
- `done` out 1: one-cycle pulse when a job completes.
- `aborted` out 1: one-cycle pulse when an abort is taken.
- `result_bits` out MAX_STEPS: captured core outputs, step k in bit k. Bits at or above the step count are 0.
- `final_state` out 3: core state captured after the last step.
- `core_reset` out 1: drives the core `reset` pin, active-high.
- `core_ctrl` out 1: drives the core `ctrl_in` pin.
- `core_sw` out 2: drives the core `sw_in` pin.
- `core_state_in` out 3: drives the core `state_in` pin.
- `core_out` in 1: from the core `out` pin.
- `core_state` in 3: from the core `state` pin.

## Operation
- FSM states: IDLE, LOAD, STEP, CAPTURE, GAP, DONE.
- Reset (reset_n low):
  - FSM goes to IDLE.
  - `result_bits`, `final_state`, `core_state_in`, `core_sw` and the step index clear to 0.
  - `done` and `aborted` clear to 0.
  - `core_reset` is forced high for the whole time `reset_n` is low, so the core reloads.
  - `ready` is 1.
- IDLE, on accept:
  - Latch `init_state` into `core_state_in`.
  - Latch `seq_in` and the clamped `num_steps`.
  - Clear `result_bits` and the index.
  - Go to LOAD.
  - `start` while not ready is ignored, not queued.
- LOAD: `core_reset`=1 for exactly one cycle. Next state is DONE if the step count is 0, otherwise STEP.
- STEP: `core_ctrl`=1 and `core_sw`=seq[index] for exactly one cycle. The core advances at the end of this cycle. Next state is CAPTURE.
- CAPTURE:
  - `core_ctrl`=0 and `core_sw` returns to 0.
  - At the end of the cycle: `result_bits[index]` takes `core_out`, `final_state` takes `core_state`, and the index increments.
  - If the incremented index equals the step count, go to DONE.
  - Otherwise go to GAP if STEP_GAP>0, else to STEP.
- GAP: count STEP_GAP cycles, then go to STEP.
- DONE: `done`=1 for one cycle, then IDLE. `result_bits` and `final_state` hold until the next accept.
- Zero-step job: `final_state` takes `init_state` in LOAD. `result_bits` stays 0.
- `abort` in any state other than IDLE or DONE:
  - Next state is IDLE, with `aborted`=1 for one cycle.
  - `core_ctrl` is guaranteed 0 from the next cycle.
  - Partial `result_bits` and `final_state` are retained.
  - `done` is not asserted.
- `abort` in IDLE or DONE is ignored. If `abort` and `start` occur together in IDLE, `start` wins.
- `core_reset` (except during `reset_n` low), `core_ctrl`, `core_sw`, `ready`, `done` and `aborted` are decoded from registered state only. They are glitch-free and never combinational from the inputs.

## Timing
- Let N be the clamped step count. Accept occurs at the end of cycle 0 and LOAD is cycle 1.
- For N>0:
  - STEP for step k is in cycle 2+k*(2+STEP_GAP).
  - `done` is high in cycle 2+2N+STEP_GAP*(N-1).
  - `ready` returns high the following cycle.
- For N=0: `done` is high in cycle 2.
- Back-to-back jobs: the earliest next accept is the cycle after `done`.
- `core_reset` is high while `reset_n` is low. It is also high in the LOAD cycle only when a job is accepted.
- `core_ctrl` high pulses are exactly one cycle wide and separated by at least 1+STEP_GAP low cycles.

## Test plan
Scenarios 1, 3 and 4 use a bench core model with this transition table, written as state/sw -> next state/out:

- state 0: sw0 -> 0/1, sw1 -> 0/0, sw2 -> 1/1, sw3 -> 1/1.
- state 1: sw0 -> 0/0, sw1 -> 1/1, sw2 -> 1/1, sw3 -> 1/0.

Directed scenarios:

1. Basic job: init 0, seq {2,3,1,0}, N=4, GAP=0 -> `result_bits`=16'h0005, `final_state`=0, `done` in cycle 10, exactly 4 `core_ctrl` pulses in cycles 2,4,6,8.
2. Zero steps: init 1, N=0 -> LOAD pulse, `done` in cycle 2, `result_bits`=0, `final_state`=1, no `core_ctrl` pulse.
3. Gap and clamp: STEP_GAP=2, num_steps=20, MAX_STEPS=16 -> 16 `core_ctrl` pulses spaced 4 cycles apart, `done` in cycle 64.
4. Abort: init 0, seq {2,3,1,0}, `abort` in the cycle of the second CAPTURE -> `aborted` pulse, IDLE next cycle, `result_bits`=16'h0001, no `done`.
5. Async reset mid-job: drive `reset_n` low mid-STEP -> `core_ctrl` goes 0 and `core_reset` goes 1 immediately, outputs take reset values, `ready`=1 after release.
6. Start while busy: pulse `start` during STEP -> ignored; the latched job completes unchanged.
